vga_sync_gen: RTL and testbench

//   VGA timing generator: produces hsync/vsync plus per-pixel x/y coordinates and pxl_en
//   for the downstream pixel-colour generator. That generator consumes x/y/pxl_en and

---
 rtl/vga_sync_gen_pkg.sv | 29 ++
 rtl/vga_axis_cnt.sv | 52 +++++
 rtl/vga_sync_gen.sv | 135 +++++++++++++
 tb/tb_vga_sync_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// VGA sync generator shared definitions.
// Default 640x480@60 timing, sync polarities and output widths.
package vga_sync_gen_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    localparam int X_W = 10;
    localparam int Y_W = 11;

    typedef struct packed {
        logic hs;
        logic vs;
    } sync_t;

    function automatic logic sync_level(bit pol, logic act);
        return pol ? act : ~act;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One VGA timing axis: wrapping counter plus visible/sync flags.
// Flags describe the value the counter is about to load.
module vga_axis_cnt #(
    parameter int W      = 10,
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync_raw
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
    localparam logic [W:0]   ACT_E  = (W + 1)'(ACTIVE);
    localparam logic [W:0]   SYNC_B = (W + 1)'(ACTIVE + FRONT);
    localparam logic [W:0]   SYNC_E = (W + 1)'(ACTIVE + FRONT + SYNC);

    logic [W-1:0] cnt_nxt;
    logic [W:0]   nxt_x;

    assign wrap = inc && (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = cnt + W'(1);
        end
    end

    assign nxt_x    = {1'b0, cnt_nxt};
    assign active   = nxt_x < ACT_E;
    assign sync_raw = (nxt_x >= SYNC_B) && (nxt_x < SYNC_E);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel tick divider, H/V counters,
// x/y/pxl_en, line/frame pulses and pipelined hsync/vsync.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int PIPE_DLY = 1
) (
    input  logic           clk,
    input  logic           rst,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pxl_en,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (H_TOTAL > 1024) begin : g_h_chk
        $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 2048) begin : g_v_chk
        $error("vga_sync_gen: V_TOTAL exceeds 2048");
    end
    if (CLK_DIV < 1) begin : g_div_chk
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_dly_chk
        $error("vga_sync_gen: PIPE_DLY must be 0..4");
    end

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_act;
    logic          v_act;
    logic          h_sync_raw;
    logic          v_sync_raw;
    sync_t         pipe [PIPE_DLY+1];

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    vga_axis_cnt #(
        .W      (X_W),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (tick),
        .cnt      (x),
        .wrap     (h_wrap),
        .active   (h_act),
        .sync_raw (h_sync_raw)
    );

    vga_axis_cnt #(
        .W      (Y_W),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (tick & h_wrap),
        .cnt      (y),
        .wrap     (v_wrap),
        .active   (v_act),
        .sync_raw (v_sync_raw)
    );

    // pxl_en only moves on ticks, so it stays low until the first tick after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pxl_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
            if (tick) begin
                pxl_en <= h_act & v_act;
            end
        end
    end

    // Stage 0 aligns with x/y; each further stage adds one clk of lag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].hs <= h_sync_raw;
            pipe[0].vs <= v_sync_raw;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign hsync = sync_level(SYNC_POL, pipe[PIPE_DLY].hs);
    assign vsync = sync_level(SYNC_POL, pipe[PIPE_DLY].vs);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: five timing variants share clk/rst,
// expectations come from a closed-form model of ticks since reset release.
module tb_vga_sync_gen;

    localparam int N = 5;

    localparam int P_DIV [N] = '{2, 1, 1, 1, 3};
    localparam int P_HA  [N] = '{640, 8, 8, 8, 8};
    localparam int P_HF  [N] = '{16, 2, 2, 2, 2};
    localparam int P_HS  [N] = '{96, 2, 2, 2, 2};
    localparam int P_HB  [N] = '{48, 2, 2, 2, 2};
    localparam int P_VA  [N] = '{480, 4, 4, 4, 4};
    localparam int P_VF  [N] = '{10, 1, 1, 1, 1};
    localparam int P_VS  [N] = '{2, 1, 1, 1, 1};
    localparam int P_VB  [N] = '{33, 1, 1, 1, 1};
    localparam bit P_POL [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam int P_DLY [N] = '{1, 0, 2, 4, 1};

    typedef struct {
        logic [9:0]  x;
        logic [10:0] y;
        logic        pxl;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [9:0]  x_w  [N];
    logic [10:0] y_w  [N];
    logic        pxl_w[N];
    logic        hs_w [N];
    logic        vs_w [N];
    logic        ls_w [N];
    logic        fs_w [N];

    exp_t sb_q[N][$];
    int   n_checks;
    int   n_errors;
    int   cyc;

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_sync_gen #(
            .CLK_DIV  (P_DIV[g]),
            .H_ACTIVE (P_HA[g]),
            .H_FRONT  (P_HF[g]),
            .H_SYNC   (P_HS[g]),
            .H_BACK   (P_HB[g]),
            .V_ACTIVE (P_VA[g]),
            .V_FRONT  (P_VF[g]),
            .V_SYNC   (P_VS[g]),
            .V_BACK   (P_VB[g]),
            .SYNC_POL (P_POL[g]),
            .PIPE_DLY (P_DLY[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .x           (x_w[g]),
            .y           (y_w[g]),
            .pxl_en      (pxl_w[g]),
            .hsync       (hs_w[g]),
            .vsync       (vs_w[g]),
            .line_start  (ls_w[g]),
            .frame_start (fs_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // State after k clk edges since reset release (k=0: in reset)
    function automatic exp_t model(int i, int k);
        exp_t e;
        int   ht, vt, t, h, v, kd, hd, vd, td;
        logic hs_on, vs_on, tk;
        ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        t = k / P_DIV[i];
        h = t % ht;
        v = (t / ht) % vt;
        e.x = 10'(h);
        e.y = 11'(v);
        e.pxl = (t > 0) && (h < P_HA[i]) && (v < P_VA[i]);
        hs_on = 1'b0;
        vs_on = 1'b0;
        kd = k - P_DLY[i];
        if (kd >= 0) begin
            td = kd / P_DIV[i];
            hd = td % ht;
            vd = (td / ht) % vt;
            hs_on = (hd >= P_HA[i] + P_HF[i])
                 && (hd < P_HA[i] + P_HF[i] + P_HS[i]);
            vs_on = (vd >= P_VA[i] + P_VF[i])
                 && (vd < P_VA[i] + P_VF[i] + P_VS[i]);
        end
        e.hs = P_POL[i] ? hs_on : !hs_on;
        e.vs = P_POL[i] ? vs_on : !vs_on;
        tk = (k >= 1) && (k % P_DIV[i] == 0);
        e.ls = tk && (h == 0);
        e.fs = tk && (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic push_all(input int k);
        for (int i = 0; i < N; i++) begin
            sb_q[i].push_back(model(i, k));
        end
    endtask

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc%0d: got %0h expected %0h",
                     nm, i, cyc, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (sb_q[i].size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty dut%0d cyc%0d: got 0 entries expected 1",
                             i, cyc);
                end else begin
                    e = sb_q[i].pop_front();
                    chk("x", i, 32'(x_w[i]), 32'(e.x));
                    chk("y", i, 32'(y_w[i]), 32'(e.y));
                    chk("pxl_en", i, 32'(pxl_w[i]), 32'(e.pxl));
                    chk("hsync", i, 32'(hs_w[i]), 32'(e.hs));
                    chk("vsync", i, 32'(vs_w[i]), 32'(e.vs));
                    chk("line_start", i, 32'(ls_w[i]), 32'(e.ls));
                    chk("frame_start", i, 32'(fs_w[i]), 32'(e.fs));
                end
            end
        end
    end

    initial begin
        int k;
        int seg;
        rst = 1'b1;
        k = 0;
        @(posedge clk);
        #1;
        push_all(0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 7; s++) begin
            seg = (s == 0) ? 6000 : int'($urandom_range(2500, 40));
            for (int c = 0; c < seg; c++) begin
                @(posedge clk);
                k++;
                push_all(k);
            end
            if (s < 6) begin
                // reset lands between edges and must act before the next one
                @(posedge clk);
                #1 rst = 1'b1;
                k = 0;
                push_all(0);
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("sb_drained", i, 32'(sb_q[i].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
